// File: rtl/sync_fifo_flex_if.sv
// Handshake and status bundle for sync_fifo_flex. The master side drives the
// requests and the slave side (the FIFO) returns data and status.
interface sync_fifo_flex_if #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
);
    logic             FLUSH;
    logic [WIDTH-1:0] DATA_IN;
    logic             WR_EN;
    logic             RD_EN;
    logic [WIDTH-1:0] DATA_OUT;
    logic             VALID;
    logic             EMPTY;
    logic             FULL;
    logic             ALMOST_FULL;
    logic             ALMOST_EMPTY;
    logic [CW-1:0]    COUNT;
    logic             OVERFLOW;
    logic             UNDERFLOW;

    modport master (
        output FLUSH, DATA_IN, WR_EN, RD_EN,
        input  DATA_OUT, VALID, EMPTY, FULL, ALMOST_FULL, ALMOST_EMPTY,
               COUNT, OVERFLOW, UNDERFLOW
    );

    modport slave (
        input  FLUSH, DATA_IN, WR_EN, RD_EN,
        output DATA_OUT, VALID, EMPTY, FULL, ALMOST_FULL, ALMOST_EMPTY,
               COUNT, OVERFLOW, UNDERFLOW
    );
endinterface

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with arbitrary depth, programmable almost-full/empty
// thresholds, registered or fall-through output, sticky errors and flush.
module sync_fifo_flex #(
    parameter int  DEPTH     = 8,
    parameter int  WIDTH     = 8,
    parameter int  AFULL_TH  = 6,
    parameter int  AEMPTY_TH = 1,
    parameter bit  FWFT      = 1'b0,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic            CLK,
    input  logic            RST,
    sync_fifo_flex_if.slave bus
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             vld_q, vld_d;

    logic             empty;
    logic             full;
    logic             rd_acc;
    logic             wr_acc;
    logic [WIDTH-1:0] fwft_data;

    // Pointers wrap explicitly so non-power-of-two depths never index past DEPTH-1.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        empty  = (count_q == '0);
        full   = (count_q == CW'(DEPTH));
        rd_acc = !bus.FLUSH && bus.RD_EN && !empty;
        wr_acc = !bus.FLUSH && bus.WR_EN && (!full || rd_acc);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        dout_d   = dout_q;
        vld_d    = 1'b0;

        if (bus.FLUSH) begin
            // Requests in a flush cycle are dropped silently; DATA_OUT holds.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (rd_acc) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
                dout_d   = mem_q[rd_ptr_q];
                vld_d    = 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (bus.WR_EN && !wr_acc) ovf_d = 1'b1;
            if (bus.RD_EN && !rd_acc) unf_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            dout_q   <= '0;
            vld_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            dout_q   <= dout_d;
            vld_q    <= vld_d;
        end
    end

    // Storage is deliberately unreset; occupancy tracking keeps stale words unreachable.
    always_ff @(posedge CLK) begin
        if (wr_acc) mem_q[wr_ptr_q] <= bus.DATA_IN;
    end

    always_comb begin
        fwft_data        = empty ? '0 : mem_q[rd_ptr_q];
        bus.DATA_OUT     = FWFT ? fwft_data : dout_q;
        bus.VALID        = FWFT ? !empty : vld_q;
        bus.EMPTY        = empty;
        bus.FULL         = full;
        bus.ALMOST_FULL  = (count_q >= CW'(AFULL_TH));
        bus.ALMOST_EMPTY = (count_q <= CW'(AEMPTY_TH));
        bus.COUNT        = count_q;
        bus.OVERFLOW     = ovf_q;
        bus.UNDERFLOW    = unf_q;
    end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed bench for sync_fifo_flex: default registered-read FIFO, a depth-5
// instance for pointer wrap, and a fall-through instance.
module tb_sync_fifo_flex;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 CLK = ~CLK;

    sync_fifo_flex_if #(.WIDTH(8), .CW(4)) b0 ();
    sync_fifo_flex_if #(.WIDTH(8), .CW(3)) b1 ();
    sync_fifo_flex_if #(.WIDTH(8), .CW(4)) b2 ();

    sync_fifo_flex #(.DEPTH(8), .WIDTH(8), .AFULL_TH(6), .AEMPTY_TH(1), .FWFT(1'b0))
        u0 (.CLK(CLK), .RST(RST), .bus(b0));
    sync_fifo_flex #(.DEPTH(5), .WIDTH(8), .AFULL_TH(4), .AEMPTY_TH(1), .FWFT(1'b0))
        u1 (.CLK(CLK), .RST(RST), .bus(b1));
    sync_fifo_flex #(.DEPTH(8), .WIDTH(8), .AFULL_TH(6), .AEMPTY_TH(1), .FWFT(1'b1))
        u2 (.CLK(CLK), .RST(RST), .bus(b2));

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        {b0.FLUSH, b0.WR_EN, b0.RD_EN, b0.DATA_IN} = '0;
        {b1.FLUSH, b1.WR_EN, b1.RD_EN, b1.DATA_IN} = '0;
        {b2.FLUSH, b2.WR_EN, b2.RD_EN, b2.DATA_IN} = '0;

        // Reset state
        #2 RST = 1'b0;
        tick();
        tick();
        chk("rst_dout",  32'(b0.DATA_OUT), 0);
        chk("rst_valid", 32'(b0.VALID), 0);
        chk("rst_count", 32'(b0.COUNT), 0);
        chk("rst_empty", 32'(b0.EMPTY), 1);
        chk("rst_full",  32'(b0.FULL), 0);
        chk("rst_ae",    32'(b0.ALMOST_EMPTY), 1);
        chk("rst_af",    32'(b0.ALMOST_FULL), 0);
        chk("rst_ovf",   32'(b0.OVERFLOW), 0);
        chk("rst_unf",   32'(b0.UNDERFLOW), 0);
        chk("rst_fwft_valid", 32'(b2.VALID), 0);
        chk("rst_fwft_dout",  32'(b2.DATA_OUT), 0);
        RST = 1'b1;
        tick();

        // Fill 0x01..0x08
        for (int i = 1; i <= 8; i++) begin
            b0.WR_EN = 1'b1;
            b0.DATA_IN = 8'(i);
            tick();
            chk("fill_count", 32'(b0.COUNT), 32'(i));
            chk("fill_af",    32'(b0.ALMOST_FULL), (i >= 6) ? 1 : 0);
            chk("fill_full",  32'(b0.FULL), (i == 8) ? 1 : 0);
            chk("fill_empty", 32'(b0.EMPTY), 0);
        end

        // Ninth write is rejected
        b0.DATA_IN = 8'hAA;
        tick();
        chk("ovf_flag",  32'(b0.OVERFLOW), 1);
        chk("ovf_count", 32'(b0.COUNT), 8);
        chk("ovf_unf",   32'(b0.UNDERFLOW), 0);

        // Full with simultaneous read and write
        b0.DATA_IN = 8'h09;
        b0.RD_EN = 1'b1;
        tick();
        b0.WR_EN = 1'b0;
        chk("simfull_count", 32'(b0.COUNT), 8);
        chk("simfull_valid", 32'(b0.VALID), 1);
        chk("simfull_dout",  32'(b0.DATA_OUT), 8'h01);
        chk("simfull_ovf_sticky", 32'(b0.OVERFLOW), 1);

        // Drain: 0x02..0x09, 0xAA never appears
        for (int i = 0; i < 8; i++) begin
            b0.RD_EN = 1'b1;
            tick();
            chk("drain_valid", 32'(b0.VALID), 1);
            chk("drain_dout",  32'(b0.DATA_OUT), 32'(i + 2));
            chk("drain_count", 32'(b0.COUNT), 32'(7 - i));
            chk("drain_ae",    32'(b0.ALMOST_EMPTY), (7 - i <= 1) ? 1 : 0);
            chk("drain_empty", 32'(b0.EMPTY), (i == 7) ? 1 : 0);
        end
        b0.RD_EN = 1'b0;
        tick();
        chk("idle_valid", 32'(b0.VALID), 0);
        chk("idle_hold",  32'(b0.DATA_OUT), 8'h09);

        // Flush clears errors; read on empty underflows
        b0.FLUSH = 1'b1;
        tick();
        b0.FLUSH = 1'b0;
        chk("flush_ovf", 32'(b0.OVERFLOW), 0);
        chk("flush_valid", 32'(b0.VALID), 0);
        chk("flush_dout_hold", 32'(b0.DATA_OUT), 8'h09);
        b0.RD_EN = 1'b1;
        tick();
        b0.RD_EN = 1'b0;
        chk("unf_flag",  32'(b0.UNDERFLOW), 1);
        chk("unf_dout",  32'(b0.DATA_OUT), 8'h09);
        chk("unf_valid", 32'(b0.VALID), 0);

        // Empty with simultaneous read and write
        b0.FLUSH = 1'b1;
        tick();
        b0.FLUSH = 1'b0;
        chk("flush2_unf", 32'(b0.UNDERFLOW), 0);
        b0.WR_EN = 1'b1;
        b0.RD_EN = 1'b1;
        b0.DATA_IN = 8'h33;
        tick();
        b0.WR_EN = 1'b0;
        chk("simempty_count", 32'(b0.COUNT), 1);
        chk("simempty_unf",   32'(b0.UNDERFLOW), 1);
        chk("simempty_valid", 32'(b0.VALID), 0);
        tick();
        b0.RD_EN = 1'b0;
        chk("simempty_rd_valid", 32'(b0.VALID), 1);
        chk("simempty_rd_dout",  32'(b0.DATA_OUT), 8'h33);
        chk("simempty_rd_count", 32'(b0.COUNT), 0);

        // Flush mid-traffic at COUNT=3 with a concurrent write
        for (int i = 0; i < 3; i++) begin
            b0.WR_EN = 1'b1;
            b0.DATA_IN = 8'(8'h41 + i);
            tick();
        end
        chk("pre_flush_count", 32'(b0.COUNT), 3);
        b0.DATA_IN = 8'h44;
        b0.FLUSH = 1'b1;
        tick();
        b0.FLUSH = 1'b0;
        b0.WR_EN = 1'b0;
        chk("midflush_count", 32'(b0.COUNT), 0);
        chk("midflush_empty", 32'(b0.EMPTY), 1);
        chk("midflush_unf",   32'(b0.UNDERFLOW), 0);
        chk("midflush_ovf",   32'(b0.OVERFLOW), 0);
        b0.WR_EN = 1'b1;
        b0.DATA_IN = 8'h55;
        tick();
        b0.WR_EN = 1'b0;
        b0.RD_EN = 1'b1;
        tick();
        b0.RD_EN = 1'b0;
        chk("postflush_dout", 32'(b0.DATA_OUT), 8'h55);
        chk("postflush_count", 32'(b0.COUNT), 0);

        // Asynchronous reset between edges
        b0.WR_EN = 1'b1;
        b0.DATA_IN = 8'h61;
        tick();
        b0.DATA_IN = 8'h62;
        tick();
        b0.WR_EN = 1'b0;
        b0.RD_EN = 1'b1;
        tick();
        b0.RD_EN = 1'b0;
        chk("prerst_valid", 32'(b0.VALID), 1);
        chk("prerst_count", 32'(b0.COUNT), 1);
        #2 RST = 1'b0;
        #1;
        chk("arst_dout",  32'(b0.DATA_OUT), 0);
        chk("arst_valid", 32'(b0.VALID), 0);
        chk("arst_count", 32'(b0.COUNT), 0);
        chk("arst_empty", 32'(b0.EMPTY), 1);
        chk("arst_ae",    32'(b0.ALMOST_EMPTY), 1);
        RST = 1'b1;
        tick();

        // DEPTH=5: 13 in-order words across pointer wraps at occupancy 3
        for (int i = 0; i < 3; i++) begin
            b1.WR_EN = 1'b1;
            b1.DATA_IN = 8'(8'h10 + i);
            tick();
        end
        for (int k = 0; k < 10; k++) begin
            b1.WR_EN = 1'b1;
            b1.RD_EN = 1'b1;
            b1.DATA_IN = 8'(8'h13 + k);
            tick();
            chk("wrap_valid", 32'(b1.VALID), 1);
            chk("wrap_dout",  32'(b1.DATA_OUT), 32'(8'h10 + k));
            chk("wrap_count", 32'(b1.COUNT), 3);
        end
        b1.WR_EN = 1'b0;
        for (int j = 0; j < 3; j++) begin
            b1.RD_EN = 1'b1;
            tick();
            chk("wrap_drain_dout",  32'(b1.DATA_OUT), 32'(8'h1A + j));
            chk("wrap_drain_count", 32'(b1.COUNT), 32'(2 - j));
        end
        b1.RD_EN = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            b1.WR_EN = 1'b1;
            b1.DATA_IN = 8'(8'h80 + i);
            tick();
            chk("d5_count", 32'(b1.COUNT), 32'(i));
            chk("d5_af",    32'(b1.ALMOST_FULL), (i >= 4) ? 1 : 0);
            chk("d5_full",  32'(b1.FULL), (i == 5) ? 1 : 0);
        end
        tick();
        b1.WR_EN = 1'b0;
        chk("d5_ovf", 32'(b1.OVERFLOW), 1);
        chk("d5_ovf_count", 32'(b1.COUNT), 5);

        // FWFT: data falls through without RD_EN
        chk("fwft_idle_valid", 32'(b2.VALID), 0);
        b2.WR_EN = 1'b1;
        b2.DATA_IN = 8'h5A;
        tick();
        b2.WR_EN = 1'b0;
        chk("fwft_valid", 32'(b2.VALID), 1);
        chk("fwft_dout",  32'(b2.DATA_OUT), 8'h5A);
        b2.WR_EN = 1'b1;
        b2.DATA_IN = 8'h5B;
        tick();
        b2.DATA_IN = 8'h5C;
        tick();
        b2.WR_EN = 1'b0;
        chk("fwft_head_hold", 32'(b2.DATA_OUT), 8'h5A);
        chk("fwft_count3", 32'(b2.COUNT), 3);
        b2.RD_EN = 1'b1;
        tick();
        chk("fwft_pop1", 32'(b2.DATA_OUT), 8'h5B);
        tick();
        chk("fwft_pop2", 32'(b2.DATA_OUT), 8'h5C);
        tick();
        b2.RD_EN = 1'b0;
        chk("fwft_empty", 32'(b2.EMPTY), 1);
        chk("fwft_zero",  32'(b2.DATA_OUT), 0);
        chk("fwft_novalid", 32'(b2.VALID), 0);
        chk("fwft_unf", 32'(b2.UNDERFLOW), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
